// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART 8N1 transmitter.
// Optional ASCII-hex item encoding is enabled by FIFO_UART_TX_HEX_ASCII_EN.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ascii_0 = 8'h30;
  localparam logic [7:0] ascii_A = 8'h41;

  localparam int frame_data_bits = 8;

  // Maps a nibble to its uppercase ASCII hex character.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ascii_0 + {4'h0, nib};
    end
    return ascii_A + {4'h0, nib - 4'd10};
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Baud-rate divider: counts 0..cycles_per_bit-1 and flags the last count.
// Held at zero while clear is high so every bit starts on a full period.
module uart_baud_tick #(
  parameter int cycles_per_bit = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int cnt_w = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(cycles_per_bit - 1);

  logic [cnt_w-1:0] cnt_reg;
  logic [cnt_w-1:0] cnt_next;

  generate
    if (cycles_per_bit < 2) begin : g_bad_divider
      $error("uart_baud_tick: cycles_per_bit must be >= 2");
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (clear || (cnt_reg == cnt_last)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = (cnt_reg == cnt_last);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one item per frame from a FIFO read port and sends it as UART 8N1.
// Define FIFO_UART_TX_HEX_ASCII_EN to send each 4-bit item as an ASCII hex digit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int clk_mhz   = 50,
  parameter int baud_rate = 115200,
  parameter int width     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             empty,
  input  logic [width-1:0] read_data,
  output logic             pop,
  output logic             uart_tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int cycles_per_bit = clk_mhz * 1_000_000 / baud_rate;

  tx_state_t  state_reg;
  tx_state_t  state_next;
  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic [2:0] bit_reg;
  logic [2:0] bit_next;
  logic       tx_reg;
  logic       tx_next;
  logic [7:0] item_byte;
  logic       baud_clear;
  logic       baud_tick;

  generate
    if ((width < 1) || (width > 8)) begin : g_bad_width
      $error("fifo_uart_tx: width must be in 1..8");
    end
    if (cycles_per_bit < 2) begin : g_bad_rate
      $error("fifo_uart_tx: clk_mhz/baud_rate gives fewer than 2 clocks per bit");
    end
  endgenerate

`ifdef FIFO_UART_TX_HEX_ASCII_EN
  generate
    if (width != 4) begin : g_bad_hex_width
      $error("fifo_uart_tx: ASCII hex mode needs width == 4");
      assign item_byte = 8'(read_data);
    end else begin : g_hex_byte
      assign item_byte = hex_to_ascii(read_data);
    end
  endgenerate
`else
  assign item_byte = 8'(read_data);
`endif

  // The counter is parked while idle, so the start bit gets a full period.
  assign baud_clear = (state_reg == IDLE);

  uart_baud_tick #(
    .cycles_per_bit(cycles_per_bit)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  assign pop  = (state_reg == IDLE) & ~empty & rst_n;
  assign busy = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    tx_next    = tx_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          state_next = START;
          shift_next = item_byte;
          bit_next   = '0;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_reg == 3'(frame_data_bits - 1)) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            // The next bit is driven from the pre-shift image to keep tx registered.
            shift_next = {1'b0, shift_reg[7:1]};
            bit_next   = bit_reg + 3'd1;
            tx_next    = shift_reg[1];
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud_tick) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
    end
  end

  assign uart_tx = tx_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at 4 clocks per bit with a queue-backed FIFO.
// Expected bytes follow FIFO_UART_TX_HEX_ASCII_EN when it is defined.
module tb_fifo_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       empty;
  logic [3:0] read_data;
  logic       pop;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  logic [3:0] fifo_q[$];
  logic       pop_s, tx_s, busy_s, fd_s;

`ifdef FIFO_UART_TX_HEX_ASCII_EN
  logic [7:0] exp_tab [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                               8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
`else
  logic [7:0] exp_tab [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                               8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
`endif

  fifo_uart_tx #(
    .clk_mhz  (1),
    .baud_rate(250000),
    .width    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .empty     (empty),
    .read_data (read_data),
    .pop       (pop),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifo();
    empty     = (fifo_q.size() == 0);
    read_data = empty ? 4'h0 : fifo_q[0];
  endtask

  // Sample mid-cycle, then retire the head item just after the edge it was popped on.
  task automatic cycle();
    @(negedge clk);
    pop_s  = pop;
    tx_s   = uart_tx;
    busy_s = busy;
    fd_s   = frame_done;
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  // Call right after the pop cycle; follows the 40 busy clocks of one frame.
  task automatic check_frame(input logic [7:0] expb, input string tag);
    logic [39:0] tr, ex;
    logic [7:0]  rx;
    int busy_n, fd_n, fd_at, pop_n;
    busy_n = 0; fd_n = 0; fd_at = -1; pop_n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      tr[i] = tx_s;
      ex[i] = (i < 4) ? 1'b0 : (i < 36) ? expb[(i - 4) / 4] : 1'b1;
      if (busy_s) busy_n++;
      if (pop_s) pop_n++;
      if (fd_s) begin fd_n++; fd_at = i; end
    end
    for (int k = 0; k < 8; k++) rx[k] = tr[4 + 4 * k + 2];
    $display("frame %s: byte=%02h expected=%02h busy_clocks=%0d", tag, rx, expb, busy_n);
    chk({tag, "_line"}, 64'(tr), 64'(ex));
    chk({tag, "_byte"}, 64'(rx), 64'(expb));
    chk({tag, "_busy_clocks"}, 64'(busy_n), 64'd40);
    chk({tag, "_frame_done_count"}, 64'(fd_n), 64'd1);
    chk({tag, "_frame_done_clock"}, 64'(fd_at), 64'd39);
    chk({tag, "_no_pop_in_frame"}, 64'(pop_n), 64'd0);
  endtask

  initial begin
    int pops, tx_low, busy_hi;
    logic [3:0] tri_items [3];
    tri_items[0] = 4'h2; tri_items[1] = 4'h6; tri_items[2] = 4'hD;

    // Reset held with a non-empty FIFO: nothing may be popped.
    rst_n = 1'b0;
    fifo_q.push_back(4'hA);
    drive_fifo();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_pop", 64'(pop_s), 64'd0);
      chk("reset_tx", 64'(tx_s), 64'd1);
      chk("reset_busy", 64'(busy_s), 64'd0);
      chk("reset_frame_done", 64'(fd_s), 64'd0);
    end
    rst_n = 1'b1;
    cycle();
    chk("first_pop_after_reset", 64'(pop_s), 64'd1);
    check_frame(exp_tab[10], "item_A");
    cycle();
    chk("idle_after_A_pop", 64'(pop_s), 64'd0);
    chk("idle_after_A_busy", 64'(busy_s), 64'd0);
    chk("idle_after_A_tx", 64'(tx_s), 64'd1);

    // Back-to-back: each pop must land on the clock right after the frame (41 apart).
    for (int i = 0; i < 3; i++) fifo_q.push_back(tri_items[i]);
    drive_fifo();
    cycle();
    chk("b2b_pop0", 64'(pop_s), 64'd1);
    check_frame(exp_tab[2], "b2b_2");
    cycle();
    chk("b2b_pop1_at_41", 64'(pop_s), 64'd1);
    check_frame(exp_tab[6], "b2b_6");
    cycle();
    chk("b2b_pop2_at_41", 64'(pop_s), 64'd1);
    check_frame(exp_tab[13], "b2b_D");

    // Long empty stretch: line stays idle.
    pops = 0; tx_low = 0; busy_hi = 0;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (pop_s) pops++;
      if (tx_s !== 1'b1) tx_low++;
      if (busy_s) busy_hi++;
    end
    $display("empty stretch: pops=%0d tx_low=%0d busy=%0d", pops, tx_low, busy_hi);
    chk("empty_pops", 64'(pops), 64'd0);
    chk("empty_tx_low", 64'(tx_low), 64'd0);
    chk("empty_busy", 64'(busy_hi), 64'd0);

    // Asynchronous reset in the middle of data bit 3 (bit 3 is 0 for item 5).
    fifo_q.push_back(4'h5);
    fifo_q.push_back(4'h7);
    drive_fifo();
    cycle();
    chk("abort_pop", 64'(pop_s), 64'd1);
    for (int i = 0; i < 16; i++) cycle();
    #2;
    chk("abort_tx_before", 64'(uart_tx), 64'd0);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_async", 64'(uart_tx), 64'd1);
    chk("abort_busy_async", 64'(busy), 64'd0);
    chk("abort_pop_async", 64'(pop), 64'd0);
    cycle();
    chk("abort_pop_in_reset", 64'(pop_s), 64'd0);
    rst_n = 1'b1;
    cycle();
    chk("abort_next_pop", 64'(pop_s), 64'd1);
    check_frame(exp_tab[7], "after_abort_7");

    // Full sweep 0..F: one pop and one correct byte per item, in order.
    for (int i = 0; i < 16; i++) fifo_q.push_back(4'(i));
    drive_fifo();
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk($sformatf("sweep_pop_%0d", i), 64'(pop_s), 64'd1);
      check_frame(exp_tab[i], $sformatf("sweep_%0d", i));
    end
    cycle();
    chk("sweep_fifo_drained", 64'(fifo_q.size()), 64'd0);
    chk("sweep_no_extra_pop", 64'(pop_s), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Consumer end of the flip-flop FIFO. It pops items from a FIFO's read interface (empty / pop / read_data) whenever it is idle and the FIFO is non-empty. Each item is serialized as one UART 8N1 frame on uart_tx. It sits between a FIFO instance and the board uart_tx pin in lab_top, giving the FIFO a real drain instead of a key press.

Parameters:
clk_mhz, 50, system clock frequency in MHz
baud_rate, 115200, UART bit rate
width, 4, FIFO item width; legal range 1..8
cycles_per_bit, clk_mhz*1_000_000/baud_rate (integer floor), clocks per UART bit; must be >= 2 (elaboration-time check)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
empty  input  1  FIFO empty flag
read_data  input  width  FIFO head item; valid combinationally while empty=0
pop  output  1  one-cycle FIFO pop strobe
uart_tx  output  1  serial line; idle high
busy  output  1  high while a frame is in progress (state != IDLE)
frame_done  output  1  one-cycle pulse on the last clock of the stop bit

Behaviour:
- Reset (async, rst_n=0): state=IDLE, uart_tx=1, busy=0, frame_done=0, baud counter=0, bit counter=0. pop is combinationally forced 0 while rst_n=0, whatever empty is.
- pop = (state==IDLE) & ~empty & rst_n. It is combinational and lasts exactly one cycle per item, because the FSM leaves IDLE on the next edge.
- In the pop cycle, the byte is formed from read_data (see Optional Feature) and registered into a 8-bit shift register. The baud counter clears and the state goes to START.
- FSM:
  - IDLE -> START on pop.
  - START: uart_tx=0 for cycles_per_bit clocks, then -> DATA.
  - DATA: 8 bits, LSB first, each held cycles_per_bit clocks. A 3-bit counter advances on each baud tick; after bit 7 -> STOP.
  - STOP: uart_tx=1 for cycles_per_bit clocks. frame_done=1 on its last clock, then -> IDLE.
- uart_tx is registered; there are no combinational glitches on the pin.
- Latency: the start bit appears on uart_tx the clock after the pop cycle.
- Frame length is 10*cycles_per_bit clocks. IDLE lasts at least 1 clock, so the back-to-back pop-to-pop spacing is exactly 10*cycles_per_bit+1 clocks.
- The baud counter counts 0..cycles_per_bit-1 and wraps; a tick is asserted at cycles_per_bit-1. Counter width is $clog2(cycles_per_bit).
- empty is sampled only in IDLE. Changes to empty or read_data mid-frame have no effect on the frame in flight.
- Reset mid-frame: the line returns high immediately and the in-flight item is discarded; it was already popped and is not re-requested. After release, a non-empty FIFO is popped on the first clock in IDLE.
- width<8: the byte is zero-extended read_data.

Optional Feature:
Macro: FIFO_UART_TX_HEX_ASCII_EN.
- Defined: requires width==4 (elaboration error otherwise). Each item is mapped to its ASCII hex character:
  - 0..9 -> 8'h30..8'h39
  - A..F -> 8'h41..8'h46 (uppercase)
- Undefined: byte = {(8-width)'0, read_data}.
- Timing is identical in both modes.

Decomposition:
- Package fifo_uart_tx_pkg holds:
  - the state enum (IDLE, START, DATA, STOP), 2-bit
  - ASCII constants ascii_0=8'h30 and ascii_A=8'h41
  - the frame bit-count constant (8 data bits)
- One sub-module, uart_baud_tick (parameter cycles_per_bit; inputs clk, rst_n, clear; output tick), owns the baud counter.

Test Plan:
1. Reset with empty=0 -> pop=0, uart_tx=1, busy=0 throughout reset. After release, pop=1 on the first clock.
2. Single item, cycles_per_bit=4, read_data=4'hA, empty low for the pop cycle then high:
   - one pop pulse
   - uart_tx: 0 x4, then 8 data bits x4 each, then 1 x4
   - data bits with HEX_ASCII_EN (byte 8'h41): 1,0,0,0,0,0,1,0
   - data bits without it (byte 8'h0A): 0,1,0,1,0,0,0,0
   - busy high for 40 clocks; frame_done pulses on clock 40
3. Back-to-back items 2,6,D with empty low -> three pops exactly 41 clocks apart. Decoded bytes in order: 8'h32, 8'h36, 8'h44 (hex mode) or 8'h02, 8'h06, 8'h0D (raw mode).
4. empty held high for 500 clocks -> pop never asserted, uart_tx constantly 1, busy=0.
5. rst_n pulsed low during DATA bit 3 -> uart_tx=1 within the same cycle (async), busy=0. After release, the next item gives a complete fresh frame starting with the start bit.
6. Hex-mode sweep of items 0..F through the FIFO -> received bytes 8'h30..8'h39 then 8'h41..8'h46, with no item dropped or duplicated.
